memout_page_reader: RTL and testbench

MEMOUT_PAGE_READER -- requirements
Module: memout_page_reader

---
 rtl/memout_page_reader.sv | 183 ++++++++++++++++++
 tb/tb_memout_page_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memout_page_reader.sv
// Streams one page of a dual-page BRAM out over a valid/ready interface.
// Reads are credit-limited against a 4-entry FIFO so backpressure never loses data.
module memout_page_reader #(
  parameter int unsigned RAM_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  page,
  input  logic [ADDR_WIDTH-1:0] nent,
  output logic                  mem_enb,
  output logic [ADDR_WIDTH-1:0] mem_readaddr,
  input  logic [RAM_WIDTH-1:0]  mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RAM_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W        = ADDR_WIDTH - 1;
  localparam int unsigned PAGE_ENTRIES = 1 << IDX_W;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned PTR_W        = 2;
  localparam int unsigned FCNT_W       = 3;
  localparam int unsigned CREDIT_W     = 8;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    page_q;
  logic [ADDR_WIDTH-1:0]   n_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    rd_last_q;
  logic [READ_LATENCY-1:0] vpipe_q;
  logic [READ_LATENCY-1:0] lpipe_q;

  logic [RAM_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]       count_q;

  logic [ADDR_WIDTH-1:0]   nent_clamped_c;
  logic                    start_ok_c;
  logic                    pop_c, push_c;
  logic [CREDIT_W-1:0]     inflight_c, credit_c;
  logic                    issue_c, issue_last_c, done_c;
  logic [IDX_W-1:0]        issue_idx_c;
  logic                    page_sel_c;
  logic [FCNT_W-1:0]       count_d, remain_c;
  logic [PTR_W-1:0]        rd_next_c;
  logic [RAM_WIDTH-1:0]    head_data_c;
  logic                    head_last_c;

  // Request decode and read credit (words issued but not yet handed to the sink)
  always_comb begin
    nent_clamped_c = (nent > ADDR_WIDTH'(PAGE_ENTRIES)) ? ADDR_WIDTH'(PAGE_ENTRIES) : nent;
    start_ok_c     = (state_q == IDLE) && start && (nent_clamped_c != '0);
    pop_c          = out_valid && out_ready;
    push_c         = vpipe_q[READ_LATENCY-1];
    inflight_c     = CREDIT_W'(mem_enb);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_c = inflight_c + CREDIT_W'(vpipe_q[i]);
    end
    credit_c = inflight_c + CREDIT_W'(count_q) - CREDIT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_c) state_d = READ;
      READ:    if (cnt_q == n_q) state_d = DRAIN;
      DRAIN:   if (pop_c && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue and completion decisions; the first read issues straight out of IDLE
  always_comb begin
    issue_c      = 1'b0;
    issue_idx_c  = '0;
    issue_last_c = 1'b0;
    done_c       = 1'b0;
    page_sel_c   = page_q;
    case (state_q)
      IDLE: begin
        page_sel_c = page;
        if (start_ok_c) begin
          issue_c      = 1'b1;
          issue_last_c = (nent_clamped_c == ADDR_WIDTH'(1));
        end
        if (start && (nent_clamped_c == '0)) done_c = 1'b1;
      end
      READ: begin
        if ((cnt_q != n_q) && (credit_c < CREDIT_W'(FIFO_DEPTH))) begin
          issue_c      = 1'b1;
          issue_idx_c  = IDX_W'(cnt_q);
          issue_last_c = (cnt_q == n_q - ADDR_WIDTH'(1));
        end
      end
      DRAIN:   done_c = pop_c && out_last;
      default: ;
    endcase
  end

  // Next FIFO head so the stream outputs can be registered
  always_comb begin
    count_d     = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
    remain_c    = count_q - FCNT_W'(pop_c);
    rd_next_c   = rd_ptr_q + PTR_W'(1);
    head_data_c = '0;
    head_last_c = 1'b0;
    if (remain_c != '0) begin
      head_data_c = pop_c ? fifo_data_q[rd_next_c] : fifo_data_q[rd_ptr_q];
      head_last_c = pop_c ? fifo_last_q[rd_next_c] : fifo_last_q[rd_ptr_q];
    end else if (push_c) begin
      head_data_c = mem_dout;
      head_last_c = lpipe_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q] <= mem_dout;
      fifo_last_q[wr_ptr_q] <= lpipe_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_q       <= 1'b0;
      n_q          <= '0;
      cnt_q        <= '0;
      rd_last_q    <= 1'b0;
      vpipe_q      <= '0;
      lpipe_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_enb      <= 1'b0;
      mem_readaddr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (start_ok_c) begin
        page_q <= page;
        n_q    <= nent_clamped_c;
        cnt_q  <= ADDR_WIDTH'(1);
      end else if (issue_c) begin
        cnt_q  <= cnt_q + ADDR_WIDTH'(1);
      end
      mem_enb      <= issue_c;
      mem_readaddr <= issue_c ? {page_sel_c, issue_idx_c} : '0;
      rd_last_q    <= issue_c && issue_last_c;
      vpipe_q[0]   <= mem_enb;
      lpipe_q[0]   <= rd_last_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_next_c;
      count_q   <= count_d;
      out_valid <= (count_d != '0);
      out_data  <= head_data_c;
      out_last  <= head_last_c;
      busy      <= (state_d != IDLE);
      done      <= done_c;
    end
  end

endmodule

// File: tb/tb_memout_page_reader.sv
// Randomized bench for memout_page_reader with a BRAM model and a page-level reference.
module tb_memout_page_reader;

  localparam int unsigned RW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset, start, page, out_ready;
  logic [AW-1:0] nent;
  logic          mem_enb, out_valid, out_last, busy, done;
  logic [AW-1:0] mem_readaddr;
  logic [RW-1:0] mem_dout, out_data;

  memout_page_reader #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .page(page), .nent(nent),
    .mem_enb(mem_enb), .mem_readaddr(mem_readaddr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle BRAM: address in cycle C, data valid in cycle C+2
  logic [RW-1:0] ram [0:31];
  logic [RW-1:0] r1, r2;
  always @(posedge clk) begin
    if (mem_enb) r1 <= ram[mem_readaddr];
    r2 <= r1;
  end
  assign mem_dout = r2;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = ((cyc % 3) == 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Observation log
  int            addr_q[$], addr_cyc_q[$], hs_cyc_q[$], done_cyc_q[$];
  logic [RW-1:0] hs_data_q[$];
  bit            hs_last_q[$];
  bit            busy_log[int];
  int            occ_err = 0, stable_err = 0, issued = 0, hsn = 0;
  bit            hold = 0;
  logic [RW-1:0] hold_data;
  bit            hold_last;

  always @(negedge clk) begin
    busy_log[cyc] = busy;
    if (reset) begin
      issued = 0; hsn = 0; hold = 0;
    end else begin
      if (mem_enb) begin
        addr_q.push_back(int'(mem_readaddr)); addr_cyc_q.push_back(cyc); issued++;
      end
      if (issued - hsn > 4) occ_err++;
      if (hold && (!out_valid || out_data !== hold_data || out_last !== hold_last)) stable_err++;
      if (out_valid && out_ready) begin
        hs_data_q.push_back(out_data); hs_last_q.push_back(out_last); hs_cyc_q.push_back(cyc); hsn++;
      end
      if (done) done_cyc_q.push_back(cyc);
      hold = out_valid && !out_ready; hold_data = out_data; hold_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    tick(); tick();
  endtask

  // Pulse start now and wait (bounded) until done is visible; optionally poke start while busy
  task automatic launch(input logic pg, input logic [AW-1:0] n, input bit spurious,
                        output int t, output bit ok);
    page = pg; nent = n; start = 1'b1; t = cyc;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      start = 1'b0;
      page = 1'($urandom); nent = AW'($urandom);
      if (done) begin ok = 1'b1; break; end
      if (spurious && busy && ($urandom_range(0, 3) == 0)) start = 1'b1;
      tick();
    end
    start = 1'b0;
  endtask

  function automatic int exp_n(input int n);
    return (n > 16) ? 16 : n;
  endfunction

  task automatic check_ok(input string name, input bit ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s timeout: done never seen", name); end
  endtask

  task automatic test_reset();
    logic [41:0] v;
    rmode = 1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); page = 1'($urandom); nent = AW'($urandom);
      tick();
      v = {mem_enb, mem_readaddr, out_valid, out_data, out_last, busy, done};
      checks++;
      if (v !== '0) begin failures++; $display("FAIL reset_outputs cycle %0d got %h want 0", i, v); end
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    int t, a0, h0, d0; bit ok;
    ram[16] = 32'hA; ram[17] = 32'hB; ram[18] = 32'hC;
    rmode = 0; tick();
    a0 = addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    launch(1'b1, AW'(3), 1'b0, t, ok);
    settle();
    check_ok("basic", ok);
    checks++;
    if (addr_q.size() - a0 != 3 || hs_data_q.size() - h0 != 3) begin
      failures++; $display("FAIL basic_counts reads %0d words %0d want 3 3", addr_q.size() - a0, hs_data_q.size() - h0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr_q[a0+i] != 16 + i || addr_cyc_q[a0+i] != t + 1 + i) begin
          failures++; $display("FAIL basic_addr %0d got %0d@%0d want %0d@%0d", i, addr_q[a0+i], addr_cyc_q[a0+i], 16 + i, t + 1 + i);
        end
        checks++;
        if (hs_data_q[h0+i] !== RW'(10 + i) || hs_cyc_q[h0+i] != t + 4 + i || hs_last_q[h0+i] != (i == 2)) begin
          failures++; $display("FAIL basic_word %0d got %h@%0d last %0d want %h@%0d last %0d", i, hs_data_q[h0+i], hs_cyc_q[h0+i], hs_last_q[h0+i], 10 + i, t + 4 + i, i == 2);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() - d0 != 1 || done_cyc_q[d0] != t + 7) begin
      failures++; $display("FAIL basic_done count %0d want 1 at %0d", done_cyc_q.size() - d0, t + 7);
    end
    for (int c = t; c <= t + 7; c++) begin
      checks++;
      if (busy_log[c] != (c >= t + 1 && c <= t + 6)) begin
        failures++; $display("FAIL basic_busy cycle T+%0d got %0d want %0d", c - t, busy_log[c], c >= t + 1 && c <= t + 6);
      end
    end
  endtask

  task automatic test_zero();
    int t, a0, d0; bit ok;
    rmode = 1;
    a0 = addr_q.size(); d0 = done_cyc_q.size();
    launch(1'($urandom), AW'(0), 1'b0, t, ok);
    settle();
    check_ok("zero", ok);
    checks++;
    if (addr_q.size() != a0) begin failures++; $display("FAIL zero_reads got %0d want 0", addr_q.size() - a0); end
    checks++;
    if (done_cyc_q.size() - d0 != 1 || done_cyc_q[d0] != t + 1) begin
      failures++; $display("FAIL zero_done count %0d want 1 at T+1", done_cyc_q.size() - d0);
    end
    checks++;
    if (busy_log[t] || busy_log[t+1] || busy_log[t+2]) begin failures++; $display("FAIL zero_busy got 1 want 0"); end
  endtask

  // Full page under 1-of-3 backpressure
  task automatic test_stall();
    int t, a0, h0, o0, s0, base; bit ok; logic pg;
    pg = 1'($urandom); rmode = 2;
    a0 = addr_q.size(); h0 = hs_data_q.size(); o0 = occ_err; s0 = stable_err;
    launch(pg, AW'(16), 1'b0, t, ok);
    settle();
    check_ok("stall", ok);
    base = pg ? 16 : 0;
    checks++;
    if (addr_q.size() - a0 != 16 || hs_data_q.size() - h0 != 16) begin
      failures++; $display("FAIL stall_counts reads %0d words %0d want 16 16", addr_q.size() - a0, hs_data_q.size() - h0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (addr_q[a0+i] != base + i || hs_data_q[h0+i] !== ram[base+i] || hs_last_q[h0+i] != (i == 15)) begin
          failures++; $display("FAIL stall_word %0d addr %0d data %h last %0d want %0d %h %0d", i, addr_q[a0+i], hs_data_q[h0+i], hs_last_q[h0+i], base + i, ram[base+i], i == 15);
        end
      end
      checks++;
      if (addr_cyc_q[a0+15] - addr_cyc_q[a0] <= 15) begin
        failures++; $display("FAIL stall_issue_span got %0d want >15", addr_cyc_q[a0+15] - addr_cyc_q[a0]);
      end
    end
    checks++;
    if (occ_err != o0) begin failures++; $display("FAIL stall_occupancy got %0d overruns want 0", occ_err - o0); end
    checks++;
    if (stable_err != s0) begin failures++; $display("FAIL stall_hold got %0d changes want 0", stable_err - s0); end
  endtask

  task automatic test_clamp();
    int t, a0, h0; bit ok;
    rmode = 1;
    a0 = addr_q.size(); h0 = hs_data_q.size();
    launch(1'b0, AW'(20), 1'b1, t, ok);
    settle();
    check_ok("clamp", ok);
    checks++;
    if (addr_q.size() - a0 != 16 || hs_data_q.size() - h0 != 16) begin
      failures++; $display("FAIL clamp_counts reads %0d words %0d want 16 16", addr_q.size() - a0, hs_data_q.size() - h0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (addr_q[a0+i] != i || hs_data_q[h0+i] !== ram[i] || hs_last_q[h0+i] != (i == 15)) begin
          failures++; $display("FAIL clamp_word %0d addr %0d data %h last %0d want %0d %h %0d", i, addr_q[a0+i], hs_data_q[h0+i], hs_last_q[h0+i], i, ram[i], i == 15);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, h0, a0, d0; bit ok; logic pg; logic [41:0] v;
    pg = 1'($urandom); rmode = 0;
    h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    page = pg; nent = AW'(10); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (hs_data_q.size() - h0 >= 5) break;
      tick();
    end
    checks++;
    if (hs_data_q.size() - h0 < 5) begin failures++; $display("FAIL mid_progress got %0d words want 5", hs_data_q.size() - h0); end
    reset = 1'b1;
    tick();
    v = {mem_enb, mem_readaddr, out_valid, out_data, out_last, busy, done};
    checks++;
    if (v !== '0) begin failures++; $display("FAIL mid_reset_outputs got %h want 0", v); end
    reset = 1'b0;
    h0 = hs_data_q.size(); a0 = addr_q.size();
    launch(~pg, AW'(2), 1'b0, t, ok);
    settle();
    check_ok("mid_restart", ok);
    checks++;
    if (hs_data_q.size() - h0 != 2 || addr_q.size() - a0 != 2) begin
      failures++; $display("FAIL mid_restart_counts words %0d reads %0d want 2 2", hs_data_q.size() - h0, addr_q.size() - a0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (hs_data_q[h0+i] !== ram[(pg ? 0 : 16) + i] || hs_last_q[h0+i] != (i == 1)) begin
          failures++; $display("FAIL mid_restart_word %0d got %h last %0d want %h %0d", i, hs_data_q[h0+i], hs_last_q[h0+i], ram[(pg ? 0 : 16) + i], i == 1);
        end
      end
      checks++;
      if (addr_cyc_q[a0] != t + 1) begin failures++; $display("FAIL mid_restart_first_addr got %0d want %0d", addr_cyc_q[a0], t + 1); end
    end
    checks++;
    if (done_cyc_q.size() - d0 != 1) begin failures++; $display("FAIL mid_done_count got %0d want 1", done_cyc_q.size() - d0); end
  endtask

  // Random back-to-back operations, each started in the previous done cycle
  task automatic test_back_to_back();
    int t, a0, h0, d0, n; bit ok; logic pg;
    int exp_addr[$]; logic [RW-1:0] exp_data[$]; bit exp_last[$];
    rmode = 1;
    a0 = addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    for (int op = 0; op < 6; op++) begin
      pg = 1'($urandom);
      n = (op == 2) ? 0 : $urandom_range(0, 31);
      for (int i = 0; i < exp_n(n); i++) begin
        exp_addr.push_back((pg ? 16 : 0) + i);
        exp_data.push_back(ram[(pg ? 16 : 0) + i]);
        exp_last.push_back(i == exp_n(n) - 1);
      end
      launch(pg, AW'(n), 1'b1, t, ok);
      check_ok("b2b", ok);
    end
    settle();
    checks++;
    if (done_cyc_q.size() - d0 != 6) begin failures++; $display("FAIL b2b_done_count got %0d want 6", done_cyc_q.size() - d0); end
    checks++;
    if (addr_q.size() - a0 != exp_addr.size() || hs_data_q.size() - h0 != exp_data.size()) begin
      failures++; $display("FAIL b2b_counts reads %0d words %0d want %0d", addr_q.size() - a0, hs_data_q.size() - h0, exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (addr_q[a0+i] != exp_addr[i] || hs_data_q[h0+i] !== exp_data[i] || hs_last_q[h0+i] != exp_last[i]) begin
          failures++; $display("FAIL b2b_word %0d addr %0d data %h last %0d want %0d %h %0d", i, addr_q[a0+i], hs_data_q[h0+i], hs_last_q[h0+i], exp_addr[i], exp_data[i], exp_last[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = $urandom;
    reset = 1'b1; start = 1'b0; page = 1'b0; nent = '0; out_ready = 1'b0;
    test_reset();
    reset = 1'b0;
    test_basic();
    test_zero();
    test_stall();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
